imem_loader: RTL

- Program-side responder for the 8-bit CPU fetch interface: holds a small instruction RAM, answers `ReadAddress` with `instruction` in the same cycle.
- Accepts a new program as a byte stream over a valid/ready handshake.
- Holds the CPU in reset (`cpu_hold`) while loading, then releases it so execution restarts from address 0.
- Sits between the board-level program source (UART/switch loader) and the CPU's `ReadAddress`/`instruction` pins.

---
 rtl/imem_loader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: instruction RAM for the 8-bit CPU fetch port, reloadable from a
// valid/ready byte stream. While a load runs the CPU is held in reset and
// fetches return FILL. When the load ends the CPU is released and restarts
// from address 0.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, the byte
// tagged load_last is an XOR checksum of the stored bytes and is not written
// to memory.
module imem_loader #(
  parameter int         DEPTH = 32,
  parameter logic [7:0] FILL  = 8'h00
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] ReadAddress,
  output logic [7:0] instruction,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic       cpu_hold,
  output logic       load_done,
  output logic [6:0] byte_count,
  output logic       chk_err
);

  localparam int         AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);
  localparam logic [6:0] LAST_IX = 7'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_mem [DEPTH];
  logic [6:0] r_ptr;
  logic [6:0] r_byte_count;
  logic       r_load_done;

  logic       w_accept;
  logic       w_full;
  logic       w_finish;
  logic       w_store;
  logic [6:0] w_stored;

  // A byte moves only in LOAD, where load_ready is high.
  assign w_accept = (r_state == ST_LOAD) && load_valid;
  assign w_full   = (r_ptr == LAST_IX);
  assign w_finish = w_accept && (load_last || w_full);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_xsum;
  logic       r_chk_err;
  logic       w_chk_bad;

  // The checksum byte is consumed but not stored. A stream cut short by a full
  // memory is never compared.
  assign w_store   = w_accept && !load_last;
  assign w_stored  = load_last ? r_ptr : (r_ptr + 7'd1);
  assign w_chk_bad = load_last && (r_xsum != load_data);

  // Running XOR of the stored bytes, plus the sticky mismatch flag.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_xsum    <= 8'h00;
      r_chk_err <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (load_start) begin
            r_xsum    <= 8'h00;
            r_chk_err <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_store) begin
            r_xsum <= r_xsum ^ load_data;
          end
          if (w_finish) begin
            r_chk_err <= w_chk_bad;
          end
        end
        default: begin
          r_xsum <= r_xsum;
        end
      endcase
    end
  end

  assign chk_err = r_chk_err;
`else
  assign w_store  = w_accept;
  assign w_stored = r_ptr + 7'd1;
  assign chk_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. A load_start seen during LOAD or DRAIN has no effect.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (load_start) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (w_finish) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Write pointer, completed-load byte count, and the load_done pulse.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_ptr        <= 7'd0;
      r_byte_count <= 7'd0;
      r_load_done  <= 1'b0;
    end else begin
      r_load_done <= (r_state == ST_DRAIN);
      case (r_state)
        ST_RUN: begin
          if (load_start) begin
            r_ptr <= 7'd0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_ptr <= r_ptr + 7'd1;
          end
          if (w_finish) begin
            r_byte_count <= w_stored;
          end
        end
        default: begin
          r_ptr <= r_ptr;
        end
      endcase
    end
  end

  // Instruction RAM. Reset refills every entry. A load overwrites only the
  // entries it reaches.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= FILL;
      end
    end else if (w_store) begin
      r_mem[r_ptr[AW-1:0]] <= load_data;
    end
  end

  // Zero-latency fetch. The CPU sees FILL while a load is in progress.
  always_comb begin
    instruction = FILL;
    if ((r_state == ST_RUN) && (ReadAddress < DEPTH_B)) begin
      instruction = r_mem[ReadAddress[AW-1:0]];
    end else begin
      instruction = FILL;
    end
  end

  assign cpu_hold   = (r_state != ST_RUN);
  assign load_ready = (r_state == ST_LOAD);
  assign load_done  = r_load_done;
  assign byte_count = r_byte_count;

endmodule
